// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller.
//   tx_state_t     : frame FSM state encoding (3 bits)
//   PARITY_EVEN/ODD: values of the Parity_Type input
//   DW_MIN/DW_MAX  : supported range of the DATA_WIDTH parameter
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int DW_MIN = 5;
    localparam int DW_MAX = 9;

endpackage

// File: rtl/uart_tx_shift.sv
// Data serializer for the UART transmitter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data and clear the bit counter
//   cnt_clr     : clear the bit counter
//   shift       : advance one bit and bump the counter (saturates at last bit)
//   load_data   : parallel word
//   serial_bit  : bit currently at the output end of the register
//   next_bit    : bit that will be at the output end after one shift
//   last_bit    : counter is on the final data bit
module uart_tx_shift #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  cnt_clr,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  serial_bit,
    output logic                  next_bit,
    output logic                  last_bit
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load) begin
            sreg_d = load_data;
            cnt_d  = '0;
        end else begin
            if (cnt_clr) begin
                cnt_d = '0;
            end
            if (shift) begin
                if (LSB_FIRST) begin
                    sreg_d = {1'b0, sreg_q[DATA_WIDTH-1:1]};
                end else begin
                    sreg_d = {sreg_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (cnt_q != CW'(DATA_WIDTH - 1)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign serial_bit = LSB_FIRST ? sreg_q[0] : sreg_q[DATA_WIDTH-1];
    assign next_bit   = LSB_FIRST ? sreg_q[1] : sreg_q[DATA_WIDTH-2];
    assign last_bit   = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: frame FSM, parity generation and registered TX line.
//   CLK, Reset   : system clock, asynchronous active-low reset
//   Bit_tick     : end-of-bit-period enable
//   P_DATA       : parallel data, captured on acceptance
//   Data_valid   : send request, accepted in IDLE only
//   Parity_EN    : parity bit present (captured on acceptance)
//   Parity_Type  : 0 even, 1 odd (captured on acceptance)
//   Stop_2       : two stop bits (captured on acceptance)
//   TX_OUT       : serial line, idle high
//   Busy         : high for every cycle of a frame
//   Frame_done   : one-cycle pulse in the first idle cycle after a frame
//
// state  | meaning
// IDLE   | line high, waiting for Data_valid
// START  | start bit (0)
// DATA   | data bits from the shift register
// PARITY | latched parity bit
// STOP1  | first stop bit (1)
// STOP2  | optional second stop bit (1)
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Bit_tick,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  Parity_EN,
    input  logic                  Parity_Type,
    input  logic                  Stop_2,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Frame_done
);

    if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
        $error("uart_tx_frame_ctrl: DATA_WIDTH out of supported range");
    end

    tx_state_t state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      par_en_q, par_en_d;
    logic      parity_q, parity_d;
    logic      stop2_q, stop2_d;

    logic      load, shift, cnt_clr;
    logic      serial_bit, next_bit, last_bit;

    uart_tx_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift (
        .clk        (CLK),
        .rst_n      (Reset),
        .load       (load),
        .cnt_clr    (cnt_clr),
        .shift      (shift),
        .load_data  (P_DATA),
        .serial_bit (serial_bit),
        .next_bit   (next_bit),
        .last_bit   (last_bit)
    );

    assign cnt_clr = (state_q == START);

    // TX_OUT is registered, so each transition loads the value of the bit
    // being entered; within DATA that is the bit after the pending shift.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        par_en_d = par_en_q;
        parity_d = parity_q;
        stop2_d  = stop2_q;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_valid) begin
                    load     = 1'b1;
                    par_en_d = Parity_EN;
                    parity_d = (^P_DATA) ^ (Parity_Type == PARITY_ODD);
                    stop2_d  = Stop_2;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (Bit_tick) begin
                    state_d = DATA;
                    tx_d    = serial_bit;
                end
            end
            DATA: begin
                if (Bit_tick) begin
                    shift = 1'b1;
                    if (!last_bit) begin
                        tx_d = next_bit;
                    end else if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        state_d = STOP1;
                        tx_d    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (Bit_tick) begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
            end
            STOP1: begin
                if (Bit_tick) begin
                    tx_d = 1'b1;
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (Bit_tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            stop2_q  <= stop2_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;
    assign Frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: an 8-bit LSB-first instance and a
// 7-bit MSB-first instance. Stimulus pushes the hand-computed line sequence
// and busy length; the monitor pops and compares every busy cycle.
module tb_uart_tx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [7:0] pd8;
    logic [6:0] pd7;
    logic       dv8, dv7;
    logic       pe, pt, s2;
    logic       tx8, busy8, done8;
    logic       tx7, busy7, done7;

    always #5 CLK = ~CLK;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_dut8 (
        .CLK (CLK), .Reset (rst_n), .Bit_tick (tick), .P_DATA (pd8),
        .Data_valid (dv8), .Parity_EN (pe), .Parity_Type (pt), .Stop_2 (s2),
        .TX_OUT (tx8), .Busy (busy8), .Frame_done (done8)
    );

    uart_tx_frame_ctrl #(.DATA_WIDTH(7), .LSB_FIRST(1'b0)) u_dut7 (
        .CLK (CLK), .Reset (rst_n), .Bit_tick (tick), .P_DATA (pd7),
        .Data_valid (dv7), .Parity_EN (pe), .Parity_Type (pt), .Stop_2 (s2),
        .TX_OUT (tx7), .Busy (busy7), .Frame_done (done7)
    );

    int   checks     = 0;
    int   failures   = 0;
    int   frames_exp = 0;
    int   frames_seen = 0;
    int   run_cnt    = 0;
    bit   sel7       = 1'b0;
    logic exp_q[$];
    int   len_q[$];

    wire tx_m   = sel7 ? tx7   : tx8;
    wire busy_m = sel7 ? busy7 : busy8;
    wire done_m = sel7 ? done7 : done8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: one expected line bit per busy cycle, busy length on Frame_done.
    initial begin
        logic e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (rst_n) begin
                if (busy_m) begin
                    if (exp_q.size() == 0) begin
                        chk("tx_unexpected_busy", 32'(busy_m), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_bit", 32'(tx_m), 32'(e));
                    end
                    run_cnt++;
                end
                if (done_m) begin
                    chk("done_while_busy", 32'(busy_m), 32'd0);
                    chk("done_pulse_width", 32'(prev_done), 32'd0);
                    if (len_q.size() == 0) begin
                        chk("done_unexpected", 32'(done_m), 32'd0);
                    end else begin
                        chk("busy_length", 32'(run_cnt), 32'(len_q.pop_front()));
                    end
                    run_cnt = 0;
                    frames_seen++;
                end
                prev_done = done_m;
            end
        end
    end

    task automatic idle(input int n);
        dv8  = 1'b0;
        dv7  = 1'b0;
        tick = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // seq holds the expected line bits, first bit at seq[n-1].
    task automatic send(input bit to7, input logic [7:0] data, input bit p_en,
                        input bit p_type, input bit stop2, input logic [11:0] seq,
                        input int n, input int div, input int inject_at,
                        input int abort_at);
        sel7 = to7;
        if (to7) begin
            pd7 = data[6:0];
            dv7 = 1'b1;
        end else begin
            pd8 = data;
            dv8 = 1'b1;
        end
        pe   = p_en;
        pt   = p_type;
        s2   = stop2;
        tick = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            for (int r = 0; r < div; r++) exp_q.push_back(seq[i]);
        end
        len_q.push_back(n * div);
        frames_exp++;
        @(negedge CLK);
        dv8 = 1'b0;
        dv7 = 1'b0;
        for (int j = 1; j <= n * div; j++) begin
            if (j - 1 == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_tx_high", 32'(tx_m), 32'd1);
                chk("abort_busy_low", 32'(busy_m), 32'd0);
                chk("abort_done_low", 32'(done_m), 32'd0);
                exp_q.delete();
                len_q.delete();
                run_cnt = 0;
                frames_exp--;
                repeat (2) @(negedge CLK);
                chk("reset_hold_tx_high", 32'(tx_m), 32'd1);
                rst_n = 1'b1;
                return;
            end
            if (j == inject_at) begin
                dv8 = 1'b1;
                pd8 = 8'hFF;
                pe  = ~p_en;
                s2  = ~stop2;
            end else begin
                dv8 = 1'b0;
            end
            tick = ((j % div) == 0);
            @(negedge CLK);
        end
        dv8 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick  = 1'b1;
        pd8   = '0;
        pd7   = '0;
        dv8   = 1'b0;
        dv7   = 1'b0;
        pe    = 1'b0;
        pt    = 1'b0;
        s2    = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_tx8", 32'(tx8), 32'd1);
        chk("reset_busy8", 32'(busy8), 32'd0);
        chk("reset_done8", 32'(done8), 32'd0);
        chk("reset_tx7", 32'(tx7), 32'd1);
        chk("reset_busy7", 32'(busy7), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 0xA5, no parity, one stop
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 12'b0101001011, 10, 1, -1, -1);
        idle(2);
        // 0xA5, even parity
        send(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 12'b01010010101, 11, 1, -1, -1);
        idle(2);
        // 0xA5, odd parity, two stops
        send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 12'b010100101111, 12, 1, -1, -1);
        idle(3);
        // 0x3C, tick every 4th clock
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 12'b0001111001, 10, 4, -1, -1);
        idle(2);
        // mid-frame request ignored, then back-to-back 0x0F in the done cycle
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 12'b0101001011, 10, 1, 3, -1);
        send(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 12'b0111100001, 10, 1, -1, -1);
        idle(2);
        // reset during data bit 3, then a clean frame
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 12'b0101001011, 10, 1, -1, 4);
        idle(2);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 12'b0001111001, 10, 1, -1, -1);
        idle(2);
        // 7-bit MSB-first instance
        send(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 12'b0100000101, 10, 1, -1, -1);
        idle(2);
        send(1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 12'b01000001111, 11, 1, -1, -1);
        idle(3);

        chk("leftover_bits", 32'(exp_q.size()), 32'd0);
        chk("leftover_frames", 32'(len_q.size()), 32'd0);
        chk("frames_completed", 32'(frames_seen), 32'(frames_exp));
        chk("idle_tx8_high", 32'(tx8), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
